// File: rtl/ysyx_23060201_dmem_resp_pkg.sv
// ysyx_23060201_dmem_resp_pkg: shared encodings for the data-memory responder
// FSM states, access-size masks, default base address and LFSR seed

package ysyx_23060201_dmem_resp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [3:0]  MASK_B       = 4'b0001;
   localparam logic [3:0]  MASK_H       = 4'b0011;
   localparam logic [3:0]  MASK_W       = 4'b1111;
   localparam int          RMASK_SIGN   = 4;
   localparam logic [31:0] MEM_BASE_DEF = 32'h8000_0000;
   localparam logic [15:0] LFSR_SEED    = 16'hACE1;

   // Illegal size, or a halfword/word not naturally aligned
   function automatic logic bad_access(input logic [3:0] m,
                                       input logic [1:0] lane);
      return !((m == MASK_B) ||
               (m == MASK_H && !lane[0]) ||
               (m == MASK_W && lane == 2'b00));
   endfunction

endpackage

// File: rtl/ysyx_23060201_lfsr16.sv
// ysyx_23060201_lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11)
// Used only when YSYX_23060201_DMEM_RAND_DELAY_EN is defined

module ysyx_23060201_lfsr16
   import ysyx_23060201_dmem_resp_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic [15:0] out
);

   // Shift in the tap parity every enabled cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out <= LFSR_SEED;
      end else if (en) begin
         out <= {out[14:0], out[15] ^ out[13] ^ out[12] ^ out[10]};
      end
   end

endmodule

// File: rtl/ysyx_23060201_dmem_resp.sv
// ysyx_23060201_dmem_resp: word-organised SRAM responder for EXU loads/stores
// Define YSYX_23060201_DMEM_RAND_DELAY_EN for 0..3 random extra wait cycles

module ysyx_23060201_dmem_resp
   import ysyx_23060201_dmem_resp_pkg::*;
#(
   parameter int MEM_ADDR_WIDTH = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int DEPTH_LOG2     = 10,
   parameter logic [MEM_ADDR_WIDTH-1:0] MEM_BASE =
      MEM_ADDR_WIDTH'(MEM_BASE_DEF),
   parameter int LATENCY        = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_wen,
   input  logic [MEM_ADDR_WIDTH-1:0] req_addr,
   input  logic [7:0]                req_wmask,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   input  logic [7:0]                req_rmask,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      rsp_err
);

   localparam int         LANES  = DATA_WIDTH / 8;
   localparam logic [4:0] LAT_M1 = 5'(LATENCY - 1);

   state_t                    state;
   logic [4:0]                cnt;
   logic [4:0]                extra;
   logic [4:0]                first_cnt;
   logic                      op_wen;
   logic [MEM_ADDR_WIDTH-1:0] op_addr;
   logic [4:0]                op_mask;
   logic [DATA_WIDTH-1:0]     op_wdata;

   logic                      cur_wen;
   logic [MEM_ADDR_WIDTH-1:0] cur_addr;
   logic [4:0]                cur_mask;
   logic [DATA_WIDTH-1:0]     cur_wdata;
   logic [MEM_ADDR_WIDTH-1:0] offset;
   logic [DEPTH_LOG2-1:0]     idx;
   logic [1:0]                lane;
   logic [4:0]                lsh;
   logic                      in_range;
   logic                      acc_err;
   logic                      enter_resp;
   logic [3:0]                be;
   logic [DATA_WIDTH-1:0]     wdata_sh;
   logic [DATA_WIDTH-1:0]     rword;
   logic [DATA_WIDTH-1:0]     rshift;
   logic [DATA_WIDTH-1:0]     rd_ext;
   logic [DATA_WIDTH-1:0]     rsp_next;
   logic                      unused_bits;

   logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];

`ifdef YSYX_23060201_DMEM_RAND_DELAY_EN
   logic [15:0] lfsr_q;

   ysyx_23060201_lfsr16 u_lfsr (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .out (lfsr_q)
   );

   assign extra       = {3'b000, lfsr_q[1:0]};
   assign unused_bits = ^{req_wmask[7:4], req_rmask[7:5], lfsr_q[15:2]};
`else
   assign extra       = 5'd0;
   assign unused_bits = ^{req_wmask[7:4], req_rmask[7:5]};
`endif

   // Decode from the port while idle (L=1 completes at accept), else from the capture
   always_comb begin
      if (state == ST_IDLE) begin
         cur_wen   = req_wen;
         cur_addr  = req_addr;
         cur_mask  = req_wen ? {1'b0, req_wmask[3:0]} : req_rmask[4:0];
         cur_wdata = req_wdata;
      end else begin
         cur_wen   = op_wen;
         cur_addr  = op_addr;
         cur_mask  = op_mask;
         cur_wdata = op_wdata;
      end
   end

   assign offset   = cur_addr - MEM_BASE;
   assign in_range = (offset >> (DEPTH_LOG2 + 2)) == '0;
   assign idx      = offset[DEPTH_LOG2+1:2];
   assign lane     = cur_addr[1:0];
   assign lsh      = {lane, 3'b000};
   assign acc_err  = !in_range || bad_access(cur_mask[3:0], lane);
   assign be       = cur_mask[3:0] << lane;
   assign wdata_sh = cur_wdata << lsh;
   assign rword    = mem[idx];
   assign rshift   = rword >> lsh;

   // Trim the lane-aligned word to the access size, extending from its top bit
   always_comb begin
      rd_ext = rshift;
      unique case (1'b1)
         cur_mask[3:0] == MASK_B:
            rd_ext = {{24{cur_mask[RMASK_SIGN] & rshift[7]}}, rshift[7:0]};
         cur_mask[3:0] == MASK_H:
            rd_ext = {{16{cur_mask[RMASK_SIGN] & rshift[15]}}, rshift[15:0]};
         default:
            rd_ext = rshift;
      endcase
   end

   assign rsp_next   = (cur_wen || acc_err) ? '0 : rd_ext;
   assign first_cnt  = LAT_M1 + extra;
   assign enter_resp = (state == ST_IDLE && req_valid && first_cnt == 5'd0) ||
                       (state == ST_WAIT && cnt == 5'd1);

   // Commit a legal store as the request enters RESP; reset drops it
   always_ff @(posedge clk) begin
      if (enter_resp && cur_wen && !acc_err && !rst) begin
         for (int i = 0; i < LANES; i++) begin
            if (be[i]) mem[idx][8*i +: 8] <= wdata_sh[8*i +: 8];
         end
      end
   end

   // Request FSM: accept, count down latency, hold completion until taken
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= 5'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
         op_wen    <= 1'b0;
         op_addr   <= '0;
         op_mask   <= '0;
         op_wdata  <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_wen    <= cur_wen;
                  op_addr   <= cur_addr;
                  op_mask   <= cur_mask;
                  op_wdata  <= cur_wdata;
                  cnt       <= first_cnt;
                  req_ready <= 1'b0;
                  if (first_cnt == 5'd0) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rsp_next;
                     rsp_err   <= acc_err;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               cnt <= cnt - 5'd1;
               if (cnt == 5'd1) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rsp_next;
                  rsp_err   <= acc_err;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= 1'b1;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
